phys_regfile: RTL and testbench

//  Physical register file for the out-of-order core, replacing the single-port architectural file.
//  NUM_PREGS entries, NUM_RD combinational read ports, NUM_WR write-back ports.
//  Per-entry ready bits: cleared on rename allocation, set on write-back.

---
 rtl/phys_regfile.sv | 123 ++++++++++++
 tb/tb_phys_regfile.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/phys_regfile.sv
`default_nettype none
// ----------------------------------------------------------------------------
// Module : phys_regfile
// Brief  : Multi-ported physical register file with per-entry ready bits,
//          optional write-to-read bypass and a post-reset clear sweep.
// Rev    : 1.0  initial release
// ----------------------------------------------------------------------------
module phys_regfile #(
  parameter int DATA_WIDTH = 32,
  parameter int NUM_PREGS  = 64,
  parameter int NUM_RD     = 4,
  parameter int NUM_WR     = 2,
  parameter int BYPASS     = 1,
  localparam int AW        = $clog2(NUM_PREGS)
) (
  input  logic                         clock,
  input  logic                         reset,
  output logic                         init_done,
  input  logic [NUM_RD*AW-1:0]         rd_addr,
  output logic [NUM_RD*DATA_WIDTH-1:0] rd_data,
  output logic [NUM_RD-1:0]            rd_ready,
  input  logic [NUM_WR-1:0]            wr_en,
  input  logic [NUM_WR*AW-1:0]         wr_addr,
  input  logic [NUM_WR*DATA_WIDTH-1:0] wr_data,
  input  logic                         alloc_en,
  input  logic [AW-1:0]                alloc_addr,
  input  logic [AW-1:0]                dbg_addr,
  output logic [DATA_WIDTH-1:0]        dbg_data
);

  typedef enum logic [0:0] {
    S_CLEAR = 1'b0,
    S_RUN   = 1'b1
  } state_t;

  localparam logic [AW-1:0] c_LAST = AW'(NUM_PREGS - 1);

  state_t                  state_q;
  logic [AW-1:0]           cnt_q;
  logic [AW-1:0]           cnt_d;
  logic                    init_done_q;
  logic [DATA_WIDTH-1:0]   mem_q [NUM_PREGS];
  logic [NUM_PREGS-1:0]    ready_q;

  assign cnt_d     = cnt_q + 1'b1;
  assign init_done = init_done_q;

  // Later write ports are applied after earlier ones so the highest index wins;
  // the alloc clear follows the writes so alloc wins on the ready bit.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= S_CLEAR;
      cnt_q       <= '0;
      init_done_q <= 1'b0;
    end else begin
      case (state_q)
        S_CLEAR: begin
          mem_q[cnt_q]   <= '0;
          ready_q[cnt_q] <= 1'b1;
          cnt_q          <= cnt_d;
          if (cnt_q == c_LAST) begin
            state_q     <= S_RUN;
            init_done_q <= 1'b1;
          end
        end
        S_RUN: begin
          for (int j = 0; j < NUM_WR; j++) begin
            if (wr_en[j] && (wr_addr[j*AW +: AW] != '0)) begin
              mem_q[wr_addr[j*AW +: AW]]   <= wr_data[j*DATA_WIDTH +: DATA_WIDTH];
              ready_q[wr_addr[j*AW +: AW]] <= 1'b1;
            end
          end
          if (alloc_en && (alloc_addr != '0)) begin
            ready_q[alloc_addr] <= 1'b0;
          end
        end
        default: begin
          state_q     <= S_CLEAR;
          cnt_q       <= '0;
          init_done_q <= 1'b0;
        end
      endcase
    end
  end

  generate
    for (genvar i = 0; i < NUM_RD; i++) begin : g_rd
      logic [AW-1:0]         w_addr;
      logic [DATA_WIDTH-1:0] w_data;
      logic                  w_rdy;

      assign w_addr = rd_addr[i*AW +: AW];

      always_comb begin
        w_data = mem_q[w_addr];
        w_rdy  = ready_q[w_addr];
        if (BYPASS != 0) begin
          for (int j = 0; j < NUM_WR; j++) begin
            if (wr_en[j] && (wr_addr[j*AW +: AW] == w_addr)) begin
              w_data = wr_data[j*DATA_WIDTH +: DATA_WIDTH];
              w_rdy  = 1'b1;
            end
          end
        end
        if (w_addr == '0) begin
          w_data = '0;
          w_rdy  = 1'b1;
        end
        if (state_q != S_RUN) begin
          w_data = '0;
          w_rdy  = 1'b0;
        end
      end

      assign rd_data[i*DATA_WIDTH +: DATA_WIDTH] = w_data;
      assign rd_ready[i]                         = w_rdy;
    end
  endgenerate

  assign dbg_data = (state_q == S_RUN) ? mem_q[dbg_addr] : '0;

endmodule
`default_nettype wire

// File: tb/tb_phys_regfile.sv
`default_nettype none
// ----------------------------------------------------------------------------
// Module : tb_phys_regfile
// Brief  : Self-checking bench for phys_regfile; bypass and non-bypass builds.
// Rev    : 1.0  initial release
// ----------------------------------------------------------------------------
module tb_phys_regfile;

  localparam int DW = 32;
  localparam int NP = 64;
  localparam int AW = 6;
  localparam int NR = 4;
  localparam int NW = 2;

  logic             clock = 1'b0;
  logic             reset;
  logic [NR*AW-1:0] rd_addr;
  logic [NW-1:0]    wr_en;
  logic [NW*AW-1:0] wr_addr;
  logic [NW*DW-1:0] wr_data;
  logic             alloc_en;
  logic [AW-1:0]    alloc_addr;
  logic [AW-1:0]    dbg_addr;

  logic             init_done,  init_done_n;
  logic [NR*DW-1:0] rd_data,    rd_data_n;
  logic [NR-1:0]    rd_ready,   rd_ready_n;
  logic [DW-1:0]    dbg_data,   dbg_data_n;

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clock = ~clock;

  phys_regfile #(.DATA_WIDTH(DW), .NUM_PREGS(NP), .NUM_RD(NR), .NUM_WR(NW), .BYPASS(1)) u_dut (
    .clock(clock), .reset(reset), .init_done(init_done),
    .rd_addr(rd_addr), .rd_data(rd_data), .rd_ready(rd_ready),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .alloc_en(alloc_en), .alloc_addr(alloc_addr),
    .dbg_addr(dbg_addr), .dbg_data(dbg_data)
  );

  phys_regfile #(.DATA_WIDTH(DW), .NUM_PREGS(NP), .NUM_RD(NR), .NUM_WR(NW), .BYPASS(0)) u_dut_nb (
    .clock(clock), .reset(reset), .init_done(init_done_n),
    .rd_addr(rd_addr), .rd_data(rd_data_n), .rd_ready(rd_ready_n),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .alloc_en(alloc_en), .alloc_addr(alloc_addr),
    .dbg_addr(dbg_addr), .dbg_data(dbg_data_n)
  );

  // a*: read ports 0..2 at ra; b*: read port 3 at rb; n-prefix: BYPASS=0 build
  typedef struct packed {
    logic [1:0]  wen;
    logic [5:0]  wa0;
    logic [31:0] wd0;
    logic [5:0]  wa1;
    logic [31:0] wd1;
    logic        aen;
    logic [5:0]  aa;
    logic [5:0]  ra;
    logic [5:0]  rb;
    logic [31:0] ad;
    logic        ar;
    logic [31:0] bd;
    logic        br;
    logic [31:0] nad;
    logic        nar;
    logic [31:0] nbd;
    logic        nbr;
  } vec_t;

  vec_t vecs [15];
  vec_t exp_q [$];

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", nm, act, exp);
    end
  endtask

  task automatic idle();
    wr_en = '0; wr_addr = '0; wr_data = '0;
    alloc_en = 1'b0; alloc_addr = '0;
  endtask

  // Entered just after a reset edge, at the following negedge. Counts cycles
  // with init_done low, optionally pokes writes/allocs into the sweep.
  task automatic sweep_wait(input string tag, input bit poke);
    int zeros = 0;
    int zeros_n = 0;
    for (int c = 0; c < 200; c++) begin
      #3;
      if (!init_done_n) zeros_n++;
      if (init_done) break;
      zeros++;
      if (zeros == 5) begin
        check({tag, " sweep rd_data"},  rd_data[31:0], 32'h0);
        check({tag, " sweep rd_ready"}, {31'h0, rd_ready[0]}, 32'h0);
        check({tag, " sweep dbg_data"}, dbg_data, 32'h0);
      end
      if (poke && zeros == 20) begin
        wr_en = 2'b01; wr_addr = {6'd0, 6'd3}; wr_data = {32'h0, 32'h0000_AAAA};
        alloc_en = 1'b1; alloc_addr = 6'd4;
      end
      @(negedge clock);
      idle();
    end
    check({tag, " init_done low cycles"}, 32'(zeros), 32'd64);
    check({tag, " init_done low cycles nb"}, 32'(zeros_n), 32'd64);
  endtask

  task automatic check_all_clear(input string tag);
    for (int g = 0; g < NP / NR; g++) begin
      @(negedge clock);
      rd_addr = {6'(g*4+3), 6'(g*4+2), 6'(g*4+1), 6'(g*4)};
      #3;
      for (int p = 0; p < NR; p++) begin
        check($sformatf("%s clear p%0d data", tag, g*4+p), rd_data[p*DW +: DW], 32'h0);
        check($sformatf("%s clear p%0d ready", tag, g*4+p), {31'h0, rd_ready[p]}, 32'h1);
        check($sformatf("%s clear p%0d data nb", tag, g*4+p), rd_data_n[p*DW +: DW], 32'h0);
      end
    end
  endtask

  initial begin
    //             wen    wa0    wd0           wa1    wd1         aen   aa     ra     rb     ad            ar    bd            br    nad           nar   nbd           nbr
    vecs[0]  = '{2'b00, 6'd0,  32'h0,        6'd0,  32'h0,      1'b1, 6'd5,  6'd5,  6'd5,  32'h0,        1'b1, 32'h0,        1'b1, 32'h0,        1'b1, 32'h0,        1'b1};
    vecs[1]  = '{2'b00, 6'd0,  32'h0,        6'd0,  32'h0,      1'b0, 6'd0,  6'd5,  6'd5,  32'h0,        1'b0, 32'h0,        1'b0, 32'h0,        1'b0, 32'h0,        1'b0};
    vecs[2]  = '{2'b01, 6'd5,  32'hDEADBEEF, 6'd0,  32'h0,      1'b0, 6'd0,  6'd5,  6'd0,  32'hDEADBEEF, 1'b1, 32'h0,        1'b1, 32'h0,        1'b0, 32'h0,        1'b1};
    vecs[3]  = '{2'b00, 6'd0,  32'h0,        6'd0,  32'h0,      1'b0, 6'd0,  6'd5,  6'd5,  32'hDEADBEEF, 1'b1, 32'hDEADBEEF, 1'b1, 32'hDEADBEEF, 1'b1, 32'hDEADBEEF, 1'b1};
    vecs[4]  = '{2'b11, 6'd7,  32'h11,       6'd7,  32'h22,     1'b0, 6'd0,  6'd7,  6'd7,  32'h22,       1'b1, 32'h22,       1'b1, 32'h0,        1'b1, 32'h0,        1'b1};
    vecs[5]  = '{2'b00, 6'd0,  32'h0,        6'd0,  32'h0,      1'b0, 6'd0,  6'd7,  6'd5,  32'h22,       1'b1, 32'hDEADBEEF, 1'b1, 32'h22,       1'b1, 32'hDEADBEEF, 1'b1};
    vecs[6]  = '{2'b01, 6'd0,  32'hFFFFFFFF, 6'd0,  32'h0,      1'b1, 6'd0,  6'd0,  6'd0,  32'h0,        1'b1, 32'h0,        1'b1, 32'h0,        1'b1, 32'h0,        1'b1};
    vecs[7]  = '{2'b00, 6'd0,  32'h0,        6'd0,  32'h0,      1'b0, 6'd0,  6'd0,  6'd7,  32'h0,        1'b1, 32'h22,       1'b1, 32'h0,        1'b1, 32'h22,       1'b1};
    vecs[8]  = '{2'b10, 6'd0,  32'h0,        6'd9,  32'h33,     1'b1, 6'd9,  6'd9,  6'd9,  32'h33,       1'b1, 32'h33,       1'b1, 32'h0,        1'b1, 32'h0,        1'b1};
    vecs[9]  = '{2'b00, 6'd0,  32'h0,        6'd0,  32'h0,      1'b0, 6'd0,  6'd9,  6'd9,  32'h33,       1'b0, 32'h33,       1'b0, 32'h33,       1'b0, 32'h33,       1'b0};
    vecs[10] = '{2'b00, 6'd0,  32'h0,        6'd0,  32'h0,      1'b0, 6'd0,  6'd3,  6'd4,  32'h0,        1'b1, 32'h0,        1'b1, 32'h0,        1'b1, 32'h0,        1'b1};
    vecs[11] = '{2'b11, 6'd12, 32'hA5,       6'd13, 32'h5A,     1'b0, 6'd0,  6'd12, 6'd13, 32'hA5,       1'b1, 32'h5A,       1'b1, 32'h0,        1'b1, 32'h0,        1'b1};
    vecs[12] = '{2'b00, 6'd0,  32'h0,        6'd0,  32'h0,      1'b0, 6'd0,  6'd13, 6'd12, 32'h5A,       1'b1, 32'hA5,       1'b1, 32'h5A,       1'b1, 32'hA5,       1'b1};
    vecs[13] = '{2'b00, 6'd0,  32'h0,        6'd0,  32'h0,      1'b1, 6'd12, 6'd12, 6'd13, 32'hA5,       1'b1, 32'h5A,       1'b1, 32'hA5,       1'b1, 32'h5A,       1'b1};
    vecs[14] = '{2'b00, 6'd0,  32'h0,        6'd0,  32'h0,      1'b0, 6'd0,  6'd12, 6'd13, 32'hA5,       1'b0, 32'h5A,       1'b1, 32'hA5,       1'b0, 32'h5A,       1'b1};

    idle();
    rd_addr = '0; dbg_addr = '0;
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    sweep_wait("por", 1'b1);
    check_all_clear("por");

    for (int i = 0; i < 15; i++) begin
      vec_t e;
      @(negedge clock);
      wr_en      = vecs[i].wen;
      wr_addr    = {vecs[i].wa1, vecs[i].wa0};
      wr_data    = {vecs[i].wd1, vecs[i].wd0};
      alloc_en   = vecs[i].aen;
      alloc_addr = vecs[i].aa;
      rd_addr    = {vecs[i].rb, vecs[i].ra, vecs[i].ra, vecs[i].ra};
      dbg_addr   = vecs[i].ra;
      exp_q.push_back(vecs[i]);
      #3;
      e = exp_q.pop_front();
      for (int p = 0; p < 3; p++) begin
        check($sformatf("v%0d port%0d data", i, p), rd_data[p*DW +: DW], e.ad);
        check($sformatf("v%0d port%0d ready", i, p), {31'h0, rd_ready[p]}, {31'h0, e.ar});
      end
      check($sformatf("v%0d port3 data", i),     rd_data[3*DW +: DW], e.bd);
      check($sformatf("v%0d port3 ready", i),    {31'h0, rd_ready[3]}, {31'h0, e.br});
      check($sformatf("v%0d nb port0 data", i),  rd_data_n[DW-1:0], e.nad);
      check($sformatf("v%0d nb port0 ready", i), {31'h0, rd_ready_n[0]}, {31'h0, e.nar});
      check($sformatf("v%0d nb port3 data", i),  rd_data_n[3*DW +: DW], e.nbd);
      check($sformatf("v%0d nb port3 ready", i), {31'h0, rd_ready_n[3]}, {31'h0, e.nbr});
      check($sformatf("v%0d dbg_data", i),       dbg_data, e.nad);
      check($sformatf("v%0d nb dbg_data", i),    dbg_data_n, e.nad);
    end

    // Mid-run reset: sweep must restart from entry 0 and wipe earlier writes
    @(negedge clock);
    idle();
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    check("midrun init_done after reset", {31'h0, init_done}, 32'h0);
    sweep_wait("midrun", 1'b0);
    check_all_clear("midrun");

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
